noise_lut_player: RTL and testbench
===================================

Name: noise_lut_player

Overview:
- Parametrised successor to the fixed 128-entry noise on-chip memory in the Rx simulation path.
- Holds a host-loadable table of signed noise samples and plays it back LANES samples per beat onto the received-sample stream.
- Each beat's output is the saturating sum of sample and noise.
- Supports programmable table length, loop or one-shot mode, freeze, and pointer clear, all through an Avalon-MM style slave.

Parameters:
- DEPTH, 128, number of noise table entries (power of two, ≥ LANES)
- ADDR_W, $clog2(DEPTH), table index width
- NOISE_W, 8, signed noise sample width (≤ SAMPLE_W)
- SAMPLE_W, 8, signed received-sample width
- LANES, 1, samples processed per valid beat (1..8)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- address  in  ADDR_W+1  MSB=0: table entry; MSB=1: CSR, low 2 bits select register
- chipselect  in  1  slave select
- write  in  1  write strobe (qualified by chipselect)
- read  in  1  read strobe (qualified by chipselect)
- writedata  in  32  write data
- readdata  out  32  read data, valid 1 cycle after read
- in_valid  in  1  input beat valid
- in_data  in  LANES*SAMPLE_W  signed samples, lane 0 in LSBs
- out_valid  out  1  output beat valid
- out_data  out  LANES*SAMPLE_W  noisy samples
- done  out  1  one-shot table exhausted

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low.
- Reset (reset=0 at a clk edge):
  - CSRs: ctrl=0, len=DEPTH.
  - State: ptr=0.
  - Outputs: done=0, out_valid=0, out_data=0, readdata=0.
  - Table contents are not reset.
- Table write: writedata[NOISE_W-1:0] goes to entry address[ADDR_W-1:0]; visible to the stream from the next cycle.
- Table read: readdata = sign-extended entry, registered, 1-cycle latency.
- CSR0 ctrl (RW):
  - bit0 enable.
  - bit1 one_shot.
  - bit2 freeze: ptr holds, noise still applied.
  - bit3 clear: write-1 pulse, reads 0; sets ptr=0, done=0.
- CSR1 len (RW, ADDR_W+1 bits): effective length L = clamp(len, LANES, DEPTH); 0 is treated as DEPTH.
- CSR2 status (RO): [ADDR_W-1:0]=ptr, bit16=done.
- CSR3: reads 0; writes ignored.
- Datapath, when in_valid=1:
  - Lane i index = (ptr+i) mod L, computed by conditional subtraction; ptr<L always holds.
  - Noise used: 0 if enable=0 or done=1, else the table entry.
  - Output: sat(in_lane + sext(noise)) to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
  - out_valid and out_data registered: 1-cycle latency, one output beat per input beat, no backpressure.
  - When in_valid=0: out_valid=0, out_data holds.
- Pointer advance, on in_valid with enable=1, freeze=0, done=0:
  - ptr_next = ptr+LANES, minus L if ≥ L.
  - One-shot: if ptr+LANES ≥ L, ptr holds at 0 and done=1 from the next cycle. The final beat still carries noise; lanes past L wrap to the table start.
- Length changed so that ptr ≥ new L: ptr forced to 0 on the next cycle.
- Simultaneous events:
  - clear with in_valid: the beat uses the old ptr; ptr becomes 0 and clear wins over the advance.
  - Table write to an index used in the same cycle: the beat uses the old value.
  - read and write in the same cycle: the write executes; readdata returns the pre-write value.
- Reset mid-stream: the output beat in flight is dropped (out_valid=0 next cycle).

Test Plan:
- Reset / passthrough: reset, enable=0, drive in_data=0x05 valid → out_data=0x05 after 1 cycle; readdata CSR1 = 128.
- Loop playback:
  - Setup: LANES=1, load table[k]=k-4, len=8, enable.
  - Stimulus: 10 beats with in_data=0.
  - Required: out = -4,-3,-2,-1,0,1,2,3,-4,-3; status ptr=2.
- Saturation:
  - Setup: table[0]=+100, table[1]=-100, len=2.
  - Stimulus: in_data=+100 → out=+127; in_data=-100 → out=-128.
- One-shot:
  - Setup: len=4, one_shot, table=1,2,3,4, in_data=10.
  - Required: out = 11,12,13,14, then 10,10; done=1 after the 4th beat; clear → done=0, ptr=0.
- Multi-lane wrap:
  - Setup: LANES=4, len=6, table[k]=k.
  - Required: beats give noise {0,1,2,3}, {4,5,0,1}, {2,3,4,5}.
- Corner cases:
  - Freeze: two beats both use the same entry.
  - clear coincident with a beat: that beat uses the old ptr, the next beat uses entry 0.
  - len set to 2 while ptr=5: next beat uses entry 0.

Source files
------------

// File: rtl/noise_lut_player_if.sv
// noise_lut_player_if
// Purpose: groups the register bus (Avalon-MM style slave) and the sample
//          stream of noise_lut_player into one bundle.
// Signals:
//   address/chipselect/write/read/writedata -> register bus request (master drives)
//   readdata                                <- registered read data, 1-cycle latency
//   in_valid/in_data                        -> received-sample beat, lane 0 in LSBs
//   out_valid/out_data                      <- noisy sample beat, 1-cycle latency
//   done                                    <- one-shot table exhausted
interface noise_lut_player_if #(
  parameter int ADDR_W   = 7,
  parameter int LANES    = 1,
  parameter int SAMPLE_W = 8
);
  logic [ADDR_W:0]             address;
  logic                        chipselect;
  logic                        write;
  logic                        read;
  logic [31:0]                 writedata;
  logic [31:0]                 readdata;
  logic                        in_valid;
  logic [LANES*SAMPLE_W-1:0]   in_data;
  logic                        out_valid;
  logic [LANES*SAMPLE_W-1:0]   out_data;
  logic                        done;

  modport master (
    output address, chipselect, write, read, writedata, in_valid, in_data,
    input  readdata, out_valid, out_data, done
  );

  modport slave (
    input  address, chipselect, write, read, writedata, in_valid, in_data,
    output readdata, out_valid, out_data, done
  );
endinterface

// File: rtl/noise_lut_player.sv
// noise_lut_player
// Purpose: host-loadable table of signed noise samples, played back LANES
//          entries per beat and added (with saturation) to the received
//          sample stream. Supports programmable length, loop / one-shot,
//          freeze and pointer clear.
// Ports:
//   clk   - clock
//   reset - synchronous, active-low reset
//   bus   - noise_lut_player_if.slave: register bus + sample stream + done
// Register map (address MSB=1):
//   0 ctrl   : bit0 enable, bit1 one_shot, bit2 freeze, bit3 clear (pulse, reads 0)
//   1 len    : table length, clamped to [LANES, DEPTH], 0 means DEPTH
//   2 status : [ADDR_W-1:0] ptr, bit16 done
//   3        : reads 0, writes ignored
module noise_lut_player #(
  parameter int DEPTH    = 128,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NOISE_W  = 8,
  parameter int SAMPLE_W = 8,
  parameter int LANES    = 1
) (
  input logic               clk,
  input logic               reset,
  noise_lut_player_if.slave bus
);

  localparam int              LW      = ADDR_W + 1;
  localparam int              SW1     = SAMPLE_W + 1;
  localparam logic [LW-1:0]   DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0]   LANES_L = LW'(LANES);

  logic [NOISE_W-1:0]         r_tbl [DEPTH];
  logic                       r_enable;
  logic                       r_one_shot;
  logic                       r_freeze;
  logic [LW-1:0]              r_len;
  logic [ADDR_W-1:0]          r_ptr;
  logic                       r_done;
  logic [31:0]                r_readdata;
  logic                       r_out_valid;
  logic [LANES*SAMPLE_W-1:0]  r_out_data;

  logic                       w_wr;
  logic                       w_rd;
  logic                       w_csr;
  logic                       w_tbl_wr;
  logic                       w_clear;
  logic                       w_advance;
  logic                       w_wrap;
  logic [LW-1:0]              w_len_eff;
  logic [LW-1:0]              w_ptr_eff;
  logic [LW-1:0]              w_ptr_sum;
  logic [NOISE_W-1:0]         w_tbl_rd;
  logic [LANES*SAMPLE_W-1:0]  w_out_data;
  logic                       w_unused;

  assign w_wr     = bus.chipselect & bus.write;
  assign w_rd     = bus.chipselect & bus.read;
  assign w_csr    = bus.address[ADDR_W];
  assign w_tbl_wr = w_wr & ~w_csr;
  assign w_clear  = w_wr & w_csr & (bus.address[1:0] == 2'd0) & bus.writedata[3];
  assign w_tbl_rd = r_tbl[bus.address[ADDR_W-1:0]];
  assign w_unused = ^bus.writedata;

  always_comb begin
    if (r_len == '0 || r_len > DEPTH_L) begin
      w_len_eff = DEPTH_L;
    end else if (r_len < LANES_L) begin
      w_len_eff = LANES_L;
    end else begin
      w_len_eff = r_len;
    end
  end

  // A freshly shortened length may leave ptr outside the table for one
  // cycle; treat it as 0 so a beat in that cycle already starts at entry 0.
  assign w_ptr_eff = ({1'b0, r_ptr} >= w_len_eff) ? '0 : {1'b0, r_ptr};

  assign w_advance = bus.in_valid & r_enable & ~r_freeze & ~r_done;
  assign w_ptr_sum = w_ptr_eff + LANES_L;
  assign w_wrap    = (w_ptr_sum >= w_len_eff);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [LW-1:0]       w_raw;
    logic [ADDR_W-1:0]   w_idx;
    logic [NOISE_W-1:0]  w_noise;
    logic [SAMPLE_W-1:0] w_in;
    logic [SW1-1:0]      w_sum;

    // ptr < L and g < LANES <= L, so one conditional subtraction is enough.
    assign w_raw   = w_ptr_eff + LW'(g);
    assign w_idx   = ADDR_W'((w_raw >= w_len_eff) ? w_raw - w_len_eff : w_raw);
    assign w_noise = (r_enable && !r_done) ? r_tbl[w_idx] : '0;
    assign w_in    = bus.in_data[g*SAMPLE_W +: SAMPLE_W];
    assign w_sum   = {w_in[SAMPLE_W-1], w_in}
                   + {{(SW1-NOISE_W){w_noise[NOISE_W-1]}}, w_noise};

    // Overflow when the two top bits of the widened sum disagree.
    assign w_out_data[g*SAMPLE_W +: SAMPLE_W] =
        (w_sum[SW1-1] == w_sum[SW1-2]) ? w_sum[SAMPLE_W-1:0] :
        (w_sum[SW1-1] ? {1'b1, {(SAMPLE_W-1){1'b0}}}
                      : {1'b0, {(SAMPLE_W-1){1'b1}}});
  end

  // Table storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_tbl_wr) begin
      r_tbl[bus.address[ADDR_W-1:0]] <= bus.writedata[NOISE_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_enable    <= 1'b0;
      r_one_shot  <= 1'b0;
      r_freeze    <= 1'b0;
      r_len       <= DEPTH_L;
      r_ptr       <= '0;
      r_done      <= 1'b0;
      r_readdata  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_wr && w_csr) begin
        case (bus.address[1:0])
          2'd0:    {r_freeze, r_one_shot, r_enable} <= bus.writedata[2:0];
          2'd1:    r_len <= bus.writedata[LW-1:0];
          default: ;
        endcase
      end

      if (w_clear) begin
        r_ptr  <= '0;
        r_done <= 1'b0;
      end else if (w_advance) begin
        if (w_wrap && r_one_shot) begin
          r_ptr  <= '0;
          r_done <= 1'b1;
        end else if (w_wrap) begin
          r_ptr <= ADDR_W'(w_ptr_sum - w_len_eff);
        end else begin
          r_ptr <= ADDR_W'(w_ptr_sum);
        end
      end else begin
        r_ptr <= ADDR_W'(w_ptr_eff);
      end

      // Reads sample registers before this cycle's write lands.
      if (w_rd) begin
        if (!w_csr) begin
          r_readdata <= {{(32-NOISE_W){w_tbl_rd[NOISE_W-1]}}, w_tbl_rd};
        end else begin
          case (bus.address[1:0])
            2'd0:    r_readdata <= {29'b0, r_freeze, r_one_shot, r_enable};
            2'd1:    r_readdata <= 32'(r_len);
            2'd2:    r_readdata <= {15'b0, r_done, 16'(r_ptr)};
            default: r_readdata <= '0;
          endcase
        end
      end

      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_out_data <= w_out_data;
      end
    end
  end

  assign bus.readdata  = r_readdata;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_noise_lut_player.sv
`timescale 1ns/1ps
module tb_noise_lut_player;
  localparam int DEPTH  = 128;
  localparam int ADDR_W = 7;
  localparam int SW     = 8;
  localparam logic [ADDR_W:0] A_CTRL = 8'h80;
  localparam logic [ADDR_W:0] A_LEN  = 8'h81;
  localparam logic [ADDR_W:0] A_STAT = 8'h82;
  localparam logic [ADDR_W:0] A_RSV  = 8'h83;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  noise_lut_player_if #(.ADDR_W(ADDR_W), .LANES(1), .SAMPLE_W(SW)) if1 ();
  noise_lut_player_if #(.ADDR_W(ADDR_W), .LANES(4), .SAMPLE_W(SW)) if4 ();

  noise_lut_player #(.DEPTH(DEPTH), .LANES(1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));
  noise_lut_player #(.DEPTH(DEPTH), .LANES(4)) u_dut4 (.clk(clk), .reset(reset), .bus(if4));

  // sel=0 addresses the 1-lane instance, sel=1 the 4-lane instance
  logic              sel = 1'b0;
  logic [ADDR_W:0]   d_addr = '0;
  logic              d_cs = 1'b0, d_wr = 1'b0, d_rd = 1'b0, d_iv = 1'b0;
  logic [31:0]       d_wdata = '0, d_idata = '0;

  assign if1.address = d_addr;  assign if4.address = d_addr;
  assign if1.write = d_wr;      assign if4.write = d_wr;
  assign if1.read = d_rd;       assign if4.read = d_rd;
  assign if1.writedata = d_wdata; assign if4.writedata = d_wdata;
  assign if1.chipselect = d_cs & ~sel;  assign if4.chipselect = d_cs & sel;
  assign if1.in_valid = d_iv & ~sel;    assign if4.in_valid = d_iv & sel;
  assign if1.in_data = d_idata[7:0];    assign if4.in_data = d_idata;

  logic [31:0] o_rd, o_data;
  logic        o_ov, o_done;
  assign o_rd   = sel ? if4.readdata : if1.readdata;
  assign o_data = sel ? if4.out_data : {24'b0, if1.out_data};
  assign o_ov   = sel ? if4.out_valid : if1.out_valid;
  assign o_done = sel ? if4.done : if1.done;

  // reference model
  int          m_tbl [2][DEPTH];
  bit          m_en [2], m_os [2], m_fr [2], m_done [2];
  int          m_len [2], m_ptr [2];
  logic [31:0] m_out [2];
  int          n_chk = 0, n_err = 0;

  function automatic int lanes_of(logic s); return s ? 4 : 1; endfunction
  function automatic int eff_len(int len, int n);
    if (len == 0 || len > DEPTH) return DEPTH;
    if (len < n) return n;
    return len;
  endfunction
  function automatic int sat(int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction
  function automatic int sx8(logic [7:0] b); return int'($signed(b)); endfunction
  function automatic logic [31:0] exp_status();
    return {15'b0, m_done[sel], 16'(m_ptr[sel])};
  endfunction

  task automatic m_reset();
    for (int s = 0; s < 2; s++) begin
      m_en[s] = 0; m_os[s] = 0; m_fr[s] = 0; m_done[s] = 0;
      m_len[s] = DEPTH; m_ptr[s] = 0; m_out[s] = '0;
    end
  endtask

  task automatic m_write(logic [ADDR_W:0] a, logic [31:0] d);
    int s = int'(sel);
    if (!a[ADDR_W]) m_tbl[s][a[ADDR_W-1:0]] = sx8(d[7:0]);
    else case (a[1:0])
      2'd0: begin
        m_en[s] = d[0]; m_os[s] = d[1]; m_fr[s] = d[2];
        if (d[3]) begin m_ptr[s] = 0; m_done[s] = 0; end
      end
      2'd1: begin
        m_len[s] = int'(d[7:0]);
        if (m_ptr[s] >= eff_len(m_len[s], lanes_of(sel))) m_ptr[s] = 0;
      end
      default: ;
    endcase
  endtask

  task automatic m_beat(logic [31:0] din, output logic [31:0] exp);
    int s = int'(sel);
    int n = lanes_of(sel);
    int L = eff_len(m_len[s], n);
    int p = m_ptr[s];
    exp = '0;
    for (int i = 0; i < n; i++) begin
      int noise = (m_en[s] && !m_done[s]) ? m_tbl[s][(p + i) % L] : 0;
      int v = sat(sx8(din[8*i +: 8]) + noise);
      exp[8*i +: 8] = 8'(v);
    end
    if (m_en[s] && !m_fr[s] && !m_done[s]) begin
      if (p + n >= L && m_os[s]) begin m_ptr[s] = 0; m_done[s] = 1; end
      else m_ptr[s] = (p + n) % L;
    end
    m_out[s] = exp;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(logic [ADDR_W:0] a, logic [31:0] d);
    @(negedge clk); d_addr = a; d_wdata = d; d_cs = 1; d_wr = 1;
    @(negedge clk); d_cs = 0; d_wr = 0;
    m_write(a, d);
  endtask

  task automatic bus_read(logic [ADDR_W:0] a, logic [31:0] exp, string tag);
    @(negedge clk); d_addr = a; d_cs = 1; d_rd = 1;
    @(negedge clk); d_cs = 0; d_rd = 0;
    chk(tag, o_rd, exp);
    chk({tag, "_idle_ov"}, 32'(o_ov), 32'd0);
    chk({tag, "_hold_data"}, o_data, m_out[sel]);
    chk({tag, "_done"}, 32'(o_done), 32'(m_done[sel]));
  endtask

  task automatic beat(logic [31:0] din, string tag);
    logic [31:0] exp;
    @(negedge clk); d_idata = din; d_iv = 1;
    m_beat(din, exp);
    @(negedge clk); d_iv = 0;
    chk(tag, o_data, exp);
    chk({tag, "_ov"}, 32'(o_ov), 32'd1);
    chk({tag, "_done"}, 32'(o_done), 32'(m_done[sel]));
  endtask

  // beat coinciding with a bus write (ctrl clear or table write)
  task automatic beat_wr(logic [31:0] din, logic [ADDR_W:0] a, logic [31:0] d, string tag);
    logic [31:0] exp;
    @(negedge clk); d_idata = din; d_iv = 1; d_addr = a; d_wdata = d; d_cs = 1; d_wr = 1;
    m_beat(din, exp);
    m_write(a, d);
    @(negedge clk); d_iv = 0; d_cs = 0; d_wr = 0;
    chk(tag, o_data, exp);
    chk({tag, "_ov"}, 32'(o_ov), 32'd1);
  endtask

  task automatic rw_same(logic [ADDR_W:0] a, logic [31:0] d, string tag);
    logic [31:0] old;
    old = 32'(m_tbl[sel][a[ADDR_W-1:0]]);
    @(negedge clk); d_addr = a; d_wdata = d; d_cs = 1; d_wr = 1; d_rd = 1;
    @(negedge clk); d_cs = 0; d_wr = 0; d_rd = 0;
    m_write(a, d);
    chk(tag, o_rd, old);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [ADDR_W:0] ra;
    m_reset();
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      chk("rst_ov", 32'(o_ov), 32'd0);
      chk("rst_data", o_data, 32'd0);
      chk("rst_done", 32'(o_done), 32'd0);
      chk("rst_rd", o_rd, 32'd0);
    end
    reset = 1;

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int k = 0; k < DEPTH; k++) bus_write(8'(k), $urandom);
    end

    // passthrough and reset CSR values on the 1-lane instance
    sel = 0;
    beat(32'h05, "passthrough");
    bus_read(A_LEN, 32'd128, "len_reset");
    bus_read(A_CTRL, 32'd0, "ctrl_reset");
    bus_write(A_RSV, 32'hFFFF_FFFF);
    bus_read(A_RSV, 32'd0, "csr3");

    // loop playback
    for (int k = 0; k < 8; k++) bus_write(8'(k), 32'(k - 4));
    bus_write(A_LEN, 32'd8);
    bus_write(A_CTRL, 32'd1);
    for (int b = 0; b < 10; b++) beat(32'd0, "loop");
    bus_read(A_STAT, exp_status(), "loop_status");
    bus_read(8'd5, 32'd1, "tbl_read");

    // saturation
    bus_write(8'd0, 32'd100);
    bus_write(8'd1, 32'hFFFF_FF9C);
    bus_write(A_LEN, 32'd2);
    beat(32'd100, "sat_pos");
    beat(32'h9C, "sat_neg");

    // one-shot
    for (int k = 0; k < 4; k++) bus_write(8'(k), 32'(k + 1));
    bus_write(A_LEN, 32'd4);
    bus_write(A_CTRL, 32'hB);
    for (int b = 0; b < 6; b++) beat(32'd10, "oneshot");
    bus_read(A_STAT, exp_status(), "oneshot_status");
    bus_write(A_CTRL, 32'hB);
    bus_read(A_STAT, exp_status(), "clear_status");
    bus_read(A_CTRL, 32'd3, "ctrl_clear_reads0");

    // freeze
    bus_write(A_LEN, 32'd8);
    bus_write(A_CTRL, 32'h9);
    beat(32'd0, "pre_freeze");
    bus_write(A_CTRL, 32'h5);
    beat(32'd0, "freeze1");
    beat(32'd0, "freeze2");

    // clear coincident with a beat
    bus_write(A_CTRL, 32'h1);
    beat(32'd0, "adv1");
    beat(32'd0, "adv2");
    beat_wr(32'd0, A_CTRL, 32'h9, "beat_clear");
    beat(32'd0, "after_clear");

    // length shrink below current ptr
    bus_write(A_CTRL, 32'h9);
    for (int b = 0; b < 5; b++) beat(32'd0, "to_ptr5");
    bus_read(A_STAT, exp_status(), "ptr5_status");
    bus_write(A_LEN, 32'd2);
    beat(32'd0, "shrink_beat");
    bus_read(A_STAT, exp_status(), "shrink_status");

    // table write and read/write coincidences
    beat_wr(32'd0, 8'd0, 32'h7F, "beat_tblwr");
    beat(32'd0, "after_tblwr");
    rw_same(8'd3, $urandom, "rw_same");
    bus_read(8'd3, 32'(m_tbl[0][3]), "rw_after");

    // multi-lane wrap
    sel = 1;
    for (int k = 0; k < 6; k++) bus_write(8'(k), 32'(k));
    bus_write(A_LEN, 32'd6);
    bus_write(A_CTRL, 32'h9);
    for (int b = 0; b < 3; b++) beat(32'd0, "lanes_wrap");
    beat($urandom, "lanes_rand");

    // randomized mix on both instances
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      bus_write(A_CTRL, 32'h9);
      for (int it = 0; it < 80; it++) begin
        ra = 8'($urandom_range(0, DEPTH - 1));
        case ($urandom_range(0, 9))
          0, 1, 2, 3: beat($urandom, "rnd_beat");
          4: bus_write(ra, $urandom);
          5: begin
            r = 32'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) r[0] = 1'b1;
            bus_write(A_CTRL, r);
          end
          6: bus_write(A_LEN, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255))
                                                           : 32'($urandom_range(0, 12)));
          7: bus_read(ra, 32'(m_tbl[sel][ra[ADDR_W-1:0]]), "rnd_tbl");
          8: bus_read(A_STAT, exp_status(), "rnd_status");
          default: bus_read(A_CTRL, {29'b0, m_fr[sel], m_os[sel], m_en[sel]}, "rnd_ctrl");
        endcase
      end
    end

    // reset while a beat is in flight
    sel = 1;
    @(negedge clk); d_idata = $urandom; d_iv = 1; reset = 0;
    @(negedge clk); d_iv = 0; reset = 1;
    m_reset();
    chk("rst_mid_ov", 32'(o_ov), 32'd0);
    chk("rst_mid_data", o_data, 32'd0);
    bus_read(A_LEN, 32'd128, "rst_mid_len");
    bus_read(A_STAT, 32'd0, "rst_mid_status");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
